// File: rtl/ram1_arbiter_if.sv
// Requester side of the RAM1/UART arbiter: instruction fetch (F) and MEM stage (D).
// Handshake: a requester raises req with its addr/we/wdata and holds it until the
//   one-cycle ack; rdata is valid in the ack cycle and req must drop in that cycle.
interface ram1_arbiter_if;
    logic        arbi_f_req;
    logic [15:0] arbi_f_addr;
    logic        arbo_f_ack;
    logic [15:0] arbo_f_rdata;
    logic        arbi_d_req;
    logic        arbi_d_we;
    logic [15:0] arbi_d_addr;
    logic [15:0] arbi_d_wdata;
    logic        arbo_d_ack;
    logic [15:0] arbo_d_rdata;

    modport master (
        output arbi_f_req, arbi_f_addr, arbi_d_req, arbi_d_we, arbi_d_addr, arbi_d_wdata,
        input  arbo_f_ack, arbo_f_rdata, arbo_d_ack, arbo_d_rdata
    );

    modport slave (
        input  arbi_f_req, arbi_f_addr, arbi_d_req, arbi_d_we, arbi_d_addr, arbi_d_wdata,
        output arbo_f_ack, arbo_f_rdata, arbo_d_ack, arbo_d_rdata
    );
endinterface

// File: rtl/ram1_arbiter.sv
// Shared RAM1/UART bus sequencer: arbitrates fetch vs. MEM stage, one transaction
// at a time, with all strobes, acks and read data registered.
module ram1_arbiter #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int          D_BURST        = 4
) (
    input  logic               arbi_clk,
    input  logic               arbi_rst,
    ram1_arbiter_if.slave      bus,
    output logic               arbo_busy,
    output logic               arbo_ram1_en,
    output logic               arbo_ram1_oe,
    output logic               arbo_ram1_we,
    output logic [15:0]        arbo_ram1_addr,
    inout  wire  [15:0]        arbio_ram1_data,
    input  logic               arbi_uart_tbre,
    input  logic               arbi_uart_tsre,
    input  logic               arbi_uart_data_ready,
    output logic               arbo_uart_wrn,
    output logic               arbo_uart_rdn,
    output logic [3:0]         arbo_dbg_state,
    output logic               arbo_dbg_bus_oe
);
    localparam int CW = $clog2(D_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(D_BURST);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD1   = 4'd1,
        S_RD2   = 4'd2,
        S_WR1   = 4'd3,
        S_WR2   = 4'd4,
        S_UR1   = 4'd5,
        S_UR2   = 4'd6,
        S_UWAIT = 4'd7,
        S_UW1   = 4'd8,
        S_UW2   = 4'd9,
        S_ST    = 4'd10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          src_f_q, src_f_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   f_rdata_q, f_rdata_d;
    logic [15:0]   d_rdata_q, d_rdata_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          busy_q, busy_d;
    logic          en_q, en_d;
    logic          oe_q, oe_d;
    logic          we_q, we_d;
    logic          wrn_q, wrn_d;
    logic          rdn_q, rdn_d;
    logic          bus_oe_q, bus_oe_d;
    logic [15:0]   bus_in;
    logic [15:0]   status;

    assign arbio_ram1_data = bus_oe_q ? wdata_q : 16'hzzzz;
    assign bus_in          = arbio_ram1_data;
    assign status          = {14'b0, arbi_uart_data_ready, arbi_uart_tbre & arbi_uart_tsre};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_f_d   = src_f_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                // D wins unless F has already waited out a full burst of D grants.
                if (bus.arbi_d_req && (!bus.arbi_f_req || cnt_q < BURST_MAX)) begin
                    cnt_d   = bus.arbi_f_req ? cnt_q + CW'(1) : '0;
                    src_f_d = 1'b0;
                    addr_d  = bus.arbi_d_addr;
                    wdata_d = bus.arbi_d_wdata;
                    if (bus.arbi_d_addr == UART_DATA_ADDR) begin
                        state_d = bus.arbi_d_we ? S_UWAIT : S_UR1;
                    end else if (bus.arbi_d_addr == UART_STAT_ADDR) begin
                        state_d = S_ST;
                        if (!bus.arbi_d_we) d_rdata_d = status;
                    end else begin
                        state_d = bus.arbi_d_we ? S_WR1 : S_RD1;
                    end
                end else if (bus.arbi_f_req) begin
                    cnt_d   = '0;
                    src_f_d = 1'b1;
                    addr_d  = bus.arbi_f_addr;
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                state_d = S_RD2;
                if (src_f_q) f_rdata_d = bus_in;
                else         d_rdata_d = bus_in;
            end
            S_RD2:   state_d = S_IDLE;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_IDLE;
            S_UR1: begin
                state_d   = S_UR2;
                d_rdata_d = bus_in;
            end
            S_UR2:   state_d = S_IDLE;
            S_UWAIT: if (arbi_uart_tbre && arbi_uart_tsre) state_d = S_UW1;
            S_UW1:   state_d = S_UW2;
            S_UW2:   state_d = S_IDLE;
            S_ST:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so every output comes straight off a flop.
        f_ack_d  = (state_d == S_RD2) && src_f_d;
        d_ack_d  = ((state_d == S_RD2) && !src_f_d) || (state_d == S_WR2) ||
                   (state_d == S_UR2) || (state_d == S_UW2) || (state_d == S_ST);
        busy_d   = (state_d != S_IDLE);
        en_d     = !((state_d == S_RD1) || (state_d == S_RD2) ||
                     (state_d == S_WR1) || (state_d == S_WR2));
        oe_d     = !((state_d == S_RD1) || (state_d == S_RD2));
        we_d     = (state_d != S_WR1);
        wrn_d    = (state_d != S_UW1);
        rdn_d    = (state_d != S_UR1);
        bus_oe_d = (state_d == S_WR1) || (state_d == S_WR2) ||
                   (state_d == S_UW1) || (state_d == S_UW2);
    end

    always_ff @(posedge arbi_clk) begin
        if (arbi_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            src_f_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            wrn_q     <= 1'b1;
            rdn_q     <= 1'b1;
            bus_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_f_q   <= src_f_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            wrn_q     <= wrn_d;
            rdn_q     <= rdn_d;
            bus_oe_q  <= bus_oe_d;
        end
    end

    assign bus.arbo_f_ack   = f_ack_q;
    assign bus.arbo_f_rdata = f_rdata_q;
    assign bus.arbo_d_ack   = d_ack_q;
    assign bus.arbo_d_rdata = d_rdata_q;
    assign arbo_busy        = busy_q;
    assign arbo_ram1_en     = en_q;
    assign arbo_ram1_oe     = oe_q;
    assign arbo_ram1_we     = we_q;
    assign arbo_ram1_addr   = addr_q;
    assign arbo_uart_wrn    = wrn_q;
    assign arbo_uart_rdn    = rdn_q;
    assign arbo_dbg_state   = state_q;
    assign arbo_dbg_bus_oe  = bus_oe_q;
endmodule

// File: tb/tb_ram1_arbiter.sv
// Directed bench for ram1_arbiter: async SRAM and UART models on the shared bus,
// hand-computed expectations checked cycle by cycle.
module tb_ram1_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        busy, en, oe, we, wrn, rdn, dbg_bus_oe;
    logic [15:0] ram_addr;
    logic [3:0]  dbg_state;
    wire  [15:0] ram1_data;
    logic        tbre, tsre, data_ready;

    logic [15:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] uart_rx_val;
    logic [15:0] uart_tx_last;
    int          uart_tx_cnt;
    logic        drv_en;
    logic [15:0] drv_val;

    int n_vec = 0;
    int n_err = 0;

    ram1_arbiter_if rif ();

    ram1_arbiter dut (
        .arbi_clk             (clk),
        .arbi_rst             (rst),
        .bus                  (rif),
        .arbo_busy            (busy),
        .arbo_ram1_en         (en),
        .arbo_ram1_oe         (oe),
        .arbo_ram1_we         (we),
        .arbo_ram1_addr       (ram_addr),
        .arbio_ram1_data      (ram1_data),
        .arbi_uart_tbre       (tbre),
        .arbi_uart_tsre       (tsre),
        .arbi_uart_data_ready (data_ready),
        .arbo_uart_wrn        (wrn),
        .arbo_uart_rdn        (rdn),
        .arbo_dbg_state       (dbg_state),
        .arbo_dbg_bus_oe      (dbg_bus_oe)
    );

    always #5 clk = ~clk;

    // Bus models: SRAM answers while en/oe are low, UART answers while rdn is low.
    assign drv_en    = (!en && !oe) || !rdn;
    assign drv_val   = !rdn ? uart_rx_val : mem[ram_addr[7:0]];
    assign ram1_data = drv_en ? drv_val : 16'hzzzz;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (!we) mem[ram_addr[7:0]] <= ram1_data;
        if (rst) begin
            uart_tx_cnt  <= 0;
            uart_tx_last <= 16'h0;
        end else if (!wrn) begin
            uart_tx_cnt  <= uart_tx_cnt + 1;
            uart_tx_last <= ram1_data;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic do_f(input string tag, input logic [15:0] a, input logic [15:0] exp);
        int lat;
        bit found;
        lat = 0;
        found = 1'b0;
        rif.arbi_f_req  = 1'b1;
        rif.arbi_f_addr = a;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            lat++;
            if (rif.arbo_f_ack) found = 1'b1;
        end
        chk({tag, "_lat"}, 16'(lat), 16'd2);
        chk({tag, "_data"}, rif.arbo_f_rdata, exp);
        rif.arbi_f_req = 1'b0;
        tick();
    endtask

    task automatic do_d(input string tag, input logic w, input logic [15:0] a,
                        input logic [15:0] wd, input int exp_lat, input logic [15:0] exp);
        int lat;
        bit found;
        lat = 0;
        found = 1'b0;
        rif.arbi_d_req   = 1'b1;
        rif.arbi_d_we    = w;
        rif.arbi_d_addr  = a;
        rif.arbi_d_wdata = wd;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            lat++;
            if (rif.arbo_d_ack) found = 1'b1;
        end
        chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        if (!w) chk({tag, "_data"}, rif.arbo_d_rdata, exp);
        rif.arbi_d_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got_f [10];
        int   acks;
        int   dual;

        rst = 1'b1;
        tbre = 1'b1;
        tsre = 1'b1;
        data_ready = 1'b0;
        pre_en = 1'b0;
        pre_addr = 8'h0;
        pre_data = 16'h0;
        uart_rx_val = 16'h0;
        rif.arbi_f_req = 1'b0;
        rif.arbi_f_addr = 16'h0;
        rif.arbi_d_req = 1'b0;
        rif.arbi_d_we = 1'b0;
        rif.arbi_d_addr = 16'h0;
        rif.arbi_d_wdata = 16'h0;

        preload(8'h40, 16'h1234);
        preload(8'h10, 16'h5A5A);
        tick();

        // Reset state
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_strobes", {11'b0, en, oe, we, wrn, rdn}, 16'h001F);
        chk("rst_addr", ram_addr, 16'h0000);
        chk("rst_acks", {14'b0, rif.arbo_f_ack, rif.arbo_d_ack}, 16'h0);
        chk("rst_f_rdata", rif.arbo_f_rdata, 16'h0);
        chk("rst_d_rdata", rif.arbo_d_rdata, 16'h0);
        chk("rst_bus_oe", 16'(dbg_bus_oe), 16'd0);
        chk("rst_state", 16'(dbg_state), 16'd0);
        rst = 1'b0;
        tick();

        // 1: F read of 0x0040
        rif.arbi_f_req = 1'b1;
        rif.arbi_f_addr = 16'h0040;
        tick();
        chk("t1_c1_en_oe", {14'b0, en, oe}, 16'h0);
        chk("t1_c1_ack", 16'(rif.arbo_f_ack), 16'd0);
        chk("t1_c1_addr", ram_addr, 16'h0040);
        chk("t1_c1_busy", 16'(busy), 16'd1);
        tick();
        chk("t1_c2_en_oe", {14'b0, en, oe}, 16'h0);
        chk("t1_c2_acks", {14'b0, rif.arbo_f_ack, rif.arbo_d_ack}, 16'h2);
        chk("t1_c2_rdata", rif.arbo_f_rdata, 16'h1234);
        rif.arbi_f_req = 1'b0;
        tick();
        chk("t1_c3_idle", {13'b0, en, rif.arbo_f_ack, busy}, 16'h4);
        chk("t1_c3_hold", rif.arbo_f_rdata, 16'h1234);

        // 2: D write 0x8000 <- BEEF; inputs disturbed after grant must be ignored
        rif.arbi_d_req = 1'b1;
        rif.arbi_d_we = 1'b1;
        rif.arbi_d_addr = 16'h8000;
        rif.arbi_d_wdata = 16'hBEEF;
        tick();
        rif.arbi_d_addr = 16'h1357;
        rif.arbi_d_wdata = 16'h0000;
        chk("t2_c1_we_en", {14'b0, we, en}, 16'h0);
        chk("t2_c1_bus", ram1_data, 16'hBEEF);
        chk("t2_c1_bus_oe", 16'(dbg_bus_oe), 16'd1);
        chk("t2_c1_addr", ram_addr, 16'h8000);
        chk("t2_c1_ack", 16'(rif.arbo_d_ack), 16'd0);
        tick();
        chk("t2_c2_we", 16'(we), 16'd1);
        chk("t2_c2_ack", 16'(rif.arbo_d_ack), 16'd1);
        chk("t2_c2_bus", ram1_data, 16'hBEEF);
        rif.arbi_d_req = 1'b0;
        tick();
        chk("t2_c3_bus_oe", 16'(dbg_bus_oe), 16'd0);
        chk("t2_c3_ack", 16'(rif.arbo_d_ack), 16'd0);
        do_d("t2_readback", 1'b0, 16'h8000, 16'h0, 2, 16'hBEEF);

        // 3: both requesters held high
        acks = 0;
        dual = 0;
        rif.arbi_f_req = 1'b1;
        rif.arbi_f_addr = 16'h0040;
        rif.arbi_d_req = 1'b1;
        rif.arbi_d_we = 1'b0;
        rif.arbi_d_addr = 16'h0010;
        for (int i = 0; i < 100 && acks < 10; i++) begin
            tick();
            if (rif.arbo_f_ack && rif.arbo_d_ack) dual++;
            if (rif.arbo_f_ack || rif.arbo_d_ack) begin
                got_f[acks] = rif.arbo_f_ack;
                if (rif.arbo_f_ack) chk("t3_f_rdata", rif.arbo_f_rdata, 16'h1234);
                else                chk("t3_d_rdata", rif.arbo_d_rdata, 16'h5A5A);
                acks++;
                if (acks == 10) begin
                    rif.arbi_f_req = 1'b0;
                    rif.arbi_d_req = 1'b0;
                end
            end
        end
        chk("t3_ack_count", 16'(acks), 16'd10);
        chk("t3_dual_ack", 16'(dual), 16'd0);
        for (int i = 0; i < acks; i++)
            chk($sformatf("t3_grant%0d", i), 16'(got_f[i]), 16'((i % 5) == 4));
        rif.arbi_f_req = 1'b0;
        rif.arbi_d_req = 1'b0;
        tick();

        // 4: UART write held in UWAIT until transmitter empty
        tbre = 1'b0;
        tsre = 1'b1;
        rif.arbi_d_req = 1'b1;
        rif.arbi_d_we = 1'b1;
        rif.arbi_d_addr = 16'hBF00;
        rif.arbi_d_wdata = 16'h0041;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_wait%0d", k), {12'b0, wrn, en, busy, rif.arbo_d_ack}, 16'hE);
            if (k < 4) tick();
        end
        tbre = 1'b1;
        tick();
        chk("t4_uw1_wrn_en", {14'b0, wrn, en}, 16'h1);
        chk("t4_uw1_bus", ram1_data, 16'h0041);
        chk("t4_uw1_ack", 16'(rif.arbo_d_ack), 16'd0);
        tick();
        chk("t4_uw2", {14'b0, wrn, rif.arbo_d_ack}, 16'h3);
        rif.arbi_d_req = 1'b0;
        tick();
        chk("t4_tx_cnt", 16'(uart_tx_cnt), 16'd1);
        chk("t4_tx_data", uart_tx_last, 16'h0041);

        // 5: status read, dropped status write, UART data read
        tbre = 1'b1;
        tsre = 1'b0;
        data_ready = 1'b1;
        rif.arbi_d_req = 1'b1;
        rif.arbi_d_we = 1'b0;
        rif.arbi_d_addr = 16'hBF01;
        tick();
        chk("t5_st_ack", 16'(rif.arbo_d_ack), 16'd1);
        chk("t5_st_rdata", rif.arbo_d_rdata, 16'h0002);
        chk("t5_st_en", 16'(en), 16'd1);
        rif.arbi_d_req = 1'b0;
        tick();
        chk("t5_idle", 16'(busy), 16'd0);
        tsre = 1'b1;
        do_d("t5_stwr", 1'b1, 16'hBF01, 16'hFFFF, 1, 16'h0);
        chk("t5_stwr_rdata", rif.arbo_d_rdata, 16'h0002);
        chk("t5_stwr_tx", 16'(uart_tx_cnt), 16'd1);
        uart_rx_val = 16'h00A5;
        rif.arbi_d_req = 1'b1;
        rif.arbi_d_we = 1'b0;
        rif.arbi_d_addr = 16'hBF00;
        tick();
        chk("t5_ur1", {13'b0, rdn, en, rif.arbo_d_ack}, 16'h2);
        tick();
        chk("t5_ur2", {14'b0, rdn, rif.arbo_d_ack}, 16'h3);
        chk("t5_ur_rdata", rif.arbo_d_rdata, 16'h00A5);
        rif.arbi_d_req = 1'b0;
        tick();

        // 6: reset in the middle of an SRAM write
        rif.arbi_d_req = 1'b1;
        rif.arbi_d_we = 1'b1;
        rif.arbi_d_addr = 16'h0050;
        rif.arbi_d_wdata = 16'h1111;
        tick();
        chk("t6_wr1_we", 16'(we), 16'd0);
        rst = 1'b1;
        tick();
        chk("t6_rst_we_en", {14'b0, we, en}, 16'h3);
        chk("t6_rst_bus_oe", 16'(dbg_bus_oe), 16'd0);
        chk("t6_rst_ack_busy", {14'b0, rif.arbo_d_ack, busy}, 16'h0);
        rst = 1'b0;
        rif.arbi_d_req = 1'b0;
        tick();
        chk("t6_post_ack", 16'(rif.arbo_d_ack), 16'd0);
        do_f("t6_fread", 16'h0040, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
